// File: rtl/uart_rx_if.sv
// Write-FIFO handshake and receiver status bundle for uart_rx.
// The receiver drives everything except the FIFO full flag.
interface uart_rx_if;
    logic       wfifo_full;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       data_vld;
    logic       frame_err;
    logic       overflow;
    logic       rx_busy;

    modport master (
        input  wfifo_full,
        output wfifo_wr_en,
        output wfifo_wr_data,
        output data_vld,
        output frame_err,
        output overflow,
        output rx_busy
    );

    modport slave (
        output wfifo_full,
        input  wfifo_wr_en,
        input  wfifo_wr_data,
        input  data_vld,
        input  frame_err,
        input  overflow,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a 3-stage synchronised line,
// good bytes written to the SDRAM write FIFO, errors reported as pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs232_rx,
    uart_rx_if.master   bus
);
    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    logic        wr_en_r;
    logic [7:0]  wr_data_r;
    logic        vld_r;
    logic        ferr_r;
    logic        ovf_r;
    logic        busy_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            wr_en_r   <= 1'b0;
            wr_data_r <= 8'h00;
            vld_r     <= 1'b0;
            ferr_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            s1 <= rs232_rx;
            s2 <= s1;
            s3 <= s2;

            wr_en_r <= 1'b0;
            vld_r   <= 1'b0;
            ferr_r  <= 1'b0;
            ovf_r   <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    // A held-low line never re-arms: a fresh falling edge is needed.
                    if (!s2 && s3) begin
                        state  <= START;
                        busy_r <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        if (!s2) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_cnt == DIV_M1) begin
                        baud_cnt       <= 16'd0;
                        shreg[bit_cnt] <= s2;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    // Leaving at mid-stop-bit lets the next start bit follow with no gap.
                    if (baud_cnt == DIV_M1) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                        if (s2) begin
                            vld_r <= 1'b1;
                            if (bus.wfifo_full) begin
                                ovf_r <= 1'b1;
                            end else begin
                                wr_en_r   <= 1'b1;
                                wr_data_r <= shreg;
                            end
                        end else begin
                            ferr_r <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wfifo_wr_en   = wr_en_r;
    assign bus.wfifo_wr_data = wr_data_r;
    assign bus.data_vld      = vld_r;
    assign bus.frame_err     = ferr_r;
    assign bus.overflow      = ovf_r;
    assign bus.rx_busy       = busy_r;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: it samples `rs232_rx` (8N1, LSB first) and pushes each good byte into the write FIFO that feeds the SDRAM write path. It is the receiving counterpart of `uart_tx`, which drains the read FIFO. It uses 16-bit mid-bit sampling counters, a 3-stage input synchroniser, and reports framing errors and FIFO overflow as single-cycle pulses.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_FREQ/BAUD` (integer division); `HALF = DIV/2`. Legal range is DIV from 4 to 65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rs232_rx`  in  1  asynchronous serial input; idle high.
- `wfifo_full`  in  1  write FIFO full flag.
- `wfifo_wr_en`  out  1  one-cycle write strobe.
- `wfifo_wr_data`  out  8  received byte; valid while `wfifo_wr_en` is high, held until the next good frame.
- `data_vld`  out  1  one-cycle pulse for every good frame, regardless of `wfifo_full`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overflow`  out  1  one-cycle pulse when a good byte is dropped because `wfifo_full` is high.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Synchroniser:
  - `s1`, `s2` and `s3` are shift registers fed from `rs232_rx`; all three reset to 1.
  - Start edge is `s2==0 && s3==1`.
  - All data sampling uses `s2`.
- Counters:
  - `baud_cnt` is 16 bits; it is cleared on every state change and otherwise increments.
  - `bit_cnt` is 3 bits.
- FSM states and transitions:
  - IDLE: go to START on a start edge. A start edge arriving in any other state is ignored.
  - START: when `baud_cnt==HALF-1`, sample. If the sample is 0, go to DATA with `bit_cnt=0`. If it is 1 (a glitch), return to IDLE silently with no pulse.
  - DATA: when `baud_cnt==DIV-1`, shift the sample into bit[`bit_cnt`] of the shift register and increment `bit_cnt`. After bit 7 (`bit_cnt` wraps to 0), go to STOP.
  - STOP: when `baud_cnt==DIV-1`, sample and always return to IDLE.
    - Sample 1 and `wfifo_full==0`: pulse `wfifo_wr_en` and `data_vld`, and load `wfifo_wr_data`.
    - Sample 1 and `wfifo_full==1`: pulse `data_vld` and `overflow`. No write; `wfifo_wr_data` is unchanged.
    - Sample 0: pulse `frame_err`. No write, no `data_vld`.
- `wfifo_full` is looked at only in the STOP sample cycle.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be received with no idle gap.
- Line held low (break): exactly one `frame_err`. No further start is detected until the line has gone high and then falls again.

## Timing
- Reset values: `wfifo_wr_en=0`, `wfifo_wr_data=8'h00`, `data_vld=0`, `frame_err=0`, `overflow=0`, `rx_busy=0`. State is IDLE, counters are 0, `s1`/`s2`/`s3` are 1.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Latency: number clock edges from E0, the first edge that samples `rs232_rx` low.
  - At E2: state becomes START.
  - At E(HALF+2): START sample; state becomes DATA.
  - At E(HALF+2+k·DIV), for k=1..8: data bit k-1 is sampled.
  - At E(HALF+2+9·DIV): stop-bit sample. The result pulses are high in the cycle following this edge.
  - With DIV=10 this edge is E97.
- `rx_busy` rises at E2 and falls at the stop-sample edge.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous) and the partial byte is discarded. After reset is released, reception resumes only on a new start edge.

## Test plan
Use `CLK_FREQ=1_000_000`, `BAUD=100_000` (DIV=10), and a 10 ns clock.
- **Single frame 0x55:** send 0x55 with stop=1 and `wfifo_full=0` → `wfifo_wr_en` and `data_vld` high for 1 cycle after E97, with `wfifo_wr_data=8'h55`. `frame_err` and `overflow` stay 0.
- **Back-to-back frames:** send 0xAA, 0x10, 0xFF with no idle bits → three writes, 100 cycles apart, with data AA, 10, FF in that order.
- **Framing error:** send 0x3C with stop=0 → `frame_err` pulses once. No `wfifo_wr_en`; `wfifo_wr_data` keeps its previous value.
- **FIFO full:** `wfifo_full=1` during 0x81 → `data_vld` and `overflow` pulse, no write. Then drop `wfifo_full` and send 0x7E → normal write of 0x7E.
- **Glitch and break:** a low pulse of 3 cycles → `rx_busy` pulses, no output pulses. Then hold the line low for 300 cycles → exactly one `frame_err`, then `rx_busy=0` until the line goes high.
- **Reset mid-frame:** assert `rst` during bit 4 of 0x55 → outputs are immediately 0. After release, send 0xC3 → one correct write of 0xC3 and nothing from the aborted frame.
